arm_multicycle_controller: RTL and testbench
============================================

Name: arm_multicycle_controller

Overview:
- Control unit for the next-generation multicycle ARM datapath (shared instruction/data memory, IR, PC update through the ALU).
- Replaces per-instruction combinational decode with a Moore main FSM plus registered NZCV flags and condition logic.
- Adds memory wait-state handshaking and a parametrised ALU-control width.
- Sits beside the datapath and drives all its mux selects and write enables.

Parameters:
- ALUCTRL_W, 3: ALUControl width. Encodings are zero-extended: ADD=0, SUB=1, AND=2, ORR=3, EOR=4.
- MEM_WAIT_EN, 1: 1 = honour mem_ready in memory states. 0 = memory is assumed single-cycle and mem_ready is ignored.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Instr  in  20  IR bits [31:12]: cond, op, funct, Rd
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result direct
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = RD2/shifted, 01 = ExtImm, 10 = constant 4
- ALUControl  out  ALUCTRL_W  ALU operation
- ImmSrc  out  2  equals Instr[27:26]
- RegSrc  out  2  {op==01, op==10}
- RegWrite  out  1  register file write
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- flags_q  out  4  registered NZCV, debug

Behaviour:
- Reset (async, reset=0):
  - state=FETCH, flags_q=0000.
  - All enables and strobes 0, all selects 0.
  - Reset mid-instruction aborts it; no partial write may occur after reset is asserted.
- Outputs are decoded from state plus Instr only (Moore). ImmSrc and RegSrc are combinational from Instr.
- Condition check, CondEx, from Instr[31:28] and flags_q:
  - Codes EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - Code 1111 evaluates false.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU=ADD, ResultSrc=10. IRWrite and PCWrite assert only when mem_ready, or always if MEM_WAIT_EN=0. Go to DECODE when the access completes; otherwise stay in FETCH.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALU=ADD (PC+8 formed).
    - If !CondEx: go to FETCH and pulse instr_done.
    - Else if op==01: go to MEMADR.
    - Else if op==10: go to BRANCH.
    - Else if funct[5]: go to EXECUTEI.
    - Else: go to EXECUTER.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALU=ADD if funct[3] (U) else SUB. Go to MEMREAD if funct[0] (L), else MEMWRITE.
  - MEMREAD: AdrSrc=1. Wait on mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. If Rd==1111, PCWrite=1 as well. Go to FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. instr_done on the completing cycle. Go to FETCH.
  - EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 / 01. ALU is decoded from cmd=funct[4:1]:
    - 0100 → ADD
    - 0010, 1010 → SUB
    - 0000 → AND
    - 1100 → ORR
    - 0001 → EOR
    - anything else → ADD
  - Flag update in EXECUTER / EXECUTEI:
    - If funct[0] (S) or cmd==1010 (CMP): flags_q<=ALUFlags at the end of this cycle.
    - Logical ops (AND/ORR/EOR) update only N and Z.
    - Then: CMP goes to FETCH with instr_done; all others go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. If Rd==15, PCWrite=1 with RegWrite=0. Go to FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALU=ADD, ResultSrc=10, PCWrite=1, instr_done=1. If funct[4] (BL), RegWrite=1 with RegSrc forcing R14. Go to FETCH.
- Instruction latencies with mem_ready=1 throughout:
  - Data-processing: 4 cycles.
  - CMP, STR, B: 3 cycles for CMP, 4 for STR, 3 for B.
  - LDR: 5 cycles.
  - Condition failed: 2 cycles.
- Each wait cycle adds one cycle to the instruction.
- Unknown op (11): treated as a condition-failed instruction (DECODE → FETCH). No writes occur.

Test Plan:
- Release reset, mem_ready=1, IR=0xE0821003 (ADD R1,R2,R3) → FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 only in cycle 4, ALUControl=000, instr_done in cycle 4.
- IR=0xE5921004 (LDR) with mem_ready low for 2 cycles in MEMREAD → 7 cycles total. RegWrite=1 only in MEMWB, ResultSrc=01. IR=0xE5821004 (STR) → MemWrite=1 exactly one cycle.
- SUBS with ALUFlags=0100 → flags_q=0100. Then IR=0x0A000002 (BEQ) → BRANCH, PCWrite=1. With flags_q=0000 → 2 cycles, PCWrite only in FETCH.
- CMP (IR=0xE1510002) → flags_q updated, no RegWrite, 3 cycles. ANDS with ALUFlags=1011 → flags_q[1:0] unchanged.
- MEM_WAIT_EN=0 build: mem_ready tied 0 → FETCH still advances every cycle.
- Assert reset in MEMWRITE with mem_ready=0 → MemWrite drops immediately (async), state=FETCH, flags_q=0000.

Source files
------------

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: Moore main FSM, registered NZCV flags and condition check.
// Drives the datapath mux selects and write enables, with optional memory wait states.
module arm_multicycle_controller #(
    parameter int unsigned ALUCTRL_W   = 3,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic                 RegWrite,
    output logic                 instr_done,
    output logic [3:0]           flags_q
);

    localparam logic [ALUCTRL_W-1:0] AluAdd = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] AluSub = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] AluAnd = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] AluOrr = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] AluEor = ALUCTRL_W'(4);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb,
        StMemWrite, StExecR, StExecI, StAluWb, StBranch
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [3:0]             r_flags;

    logic [3:0]             w_cond;
    logic [1:0]             w_op;
    logic [5:0]             w_funct;
    logic [3:0]             w_cmd;
    logic [3:0]             w_rd;
    logic                   w_cond_ex;
    logic                   w_mem_ok;
    logic                   w_is_cmp;
    logic                   w_is_logic;
    logic                   w_flag_we;
    logic [ALUCTRL_W-1:0]   w_alu_dp;
    logic                   w_unused;

    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_cmd    = Instr[12:9];
    assign w_rd     = Instr[3:0];
    // Rn field is only consumed by the datapath
    assign w_unused = ^Instr[7:4];

    assign w_mem_ok   = !MEM_WAIT_EN || mem_ready;
    assign w_is_cmp   = (w_cmd == 4'b1010);
    assign w_is_logic = (w_cmd == 4'b0000) || (w_cmd == 4'b1100) || (w_cmd == 4'b0001);
    assign w_flag_we  = ((r_state == StExecR) || (r_state == StExecI)) &&
                        (w_funct[0] || w_is_cmp);
    assign flags_q    = r_flags;

    always_comb begin
        case (w_cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = !r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = !r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = !r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = !r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] && !r_flags[2];
            4'b1001: w_cond_ex = !r_flags[1] || r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = !r_flags[2] && (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] || (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        case (w_cmd)
            4'b0100: w_alu_dp = AluAdd;
            4'b0010: w_alu_dp = AluSub;
            4'b1010: w_alu_dp = AluSub;
            4'b0000: w_alu_dp = AluAnd;
            4'b1100: w_alu_dp = AluOrr;
            4'b0001: w_alu_dp = AluEor;
            default: w_alu_dp = AluAdd;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Logical ops leave C and V untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (w_flag_we) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (!w_is_logic) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUControl  = AluAdd;
        ImmSrc      = 2'b00;
        RegSrc      = 2'b00;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        // Outputs are forced low while reset is held so nothing writes mid-abort
        if (reset) begin
            ImmSrc = w_op;
            RegSrc = {w_op == 2'b01, w_op == 2'b10};
            case (r_state)
                StFetch: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    if (w_mem_ok) begin
                        IRWrite     = 1'b1;
                        PCWrite     = 1'b1;
                        w_state_nxt = StDecode;
                    end
                end
                StDecode: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    if (!w_cond_ex || (w_op == 2'b11)) begin
                        instr_done  = 1'b1;
                        w_state_nxt = StFetch;
                    end else if (w_op == 2'b01) begin
                        w_state_nxt = StMemAdr;
                    end else if (w_op == 2'b10) begin
                        w_state_nxt = StBranch;
                    end else if (w_funct[5]) begin
                        w_state_nxt = StExecI;
                    end else begin
                        w_state_nxt = StExecR;
                    end
                end
                StMemAdr: begin
                    ALUSrcB     = 2'b01;
                    ALUControl  = w_funct[3] ? AluAdd : AluSub;
                    w_state_nxt = w_funct[0] ? StMemRead : StMemWrite;
                end
                StMemRead: begin
                    AdrSrc = 1'b1;
                    if (w_mem_ok) begin
                        w_state_nxt = StMemWb;
                    end
                end
                StMemWb: begin
                    ResultSrc   = 2'b01;
                    RegWrite    = 1'b1;
                    PCWrite     = (w_rd == 4'hF);
                    instr_done  = 1'b1;
                    w_state_nxt = StFetch;
                end
                StMemWrite: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    if (w_mem_ok) begin
                        instr_done  = 1'b1;
                        w_state_nxt = StFetch;
                    end
                end
                StExecR, StExecI: begin
                    ALUSrcB     = (r_state == StExecI) ? 2'b01 : 2'b00;
                    ALUControl  = w_alu_dp;
                    instr_done  = w_is_cmp;
                    w_state_nxt = w_is_cmp ? StFetch : StAluWb;
                end
                StAluWb: begin
                    if (w_rd == 4'hF) begin
                        PCWrite = 1'b1;
                    end else begin
                        RegWrite = 1'b1;
                    end
                    instr_done  = 1'b1;
                    w_state_nxt = StFetch;
                end
                StBranch: begin
                    ALUSrcB     = 2'b01;
                    ResultSrc   = 2'b10;
                    PCWrite     = 1'b1;
                    RegWrite    = w_funct[4];
                    instr_done  = 1'b1;
                    w_state_nxt = StFetch;
                end
                default: begin
                    w_state_nxt = StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed bench for arm_multicycle_controller: per-instruction output masks and
// cycle counts against hand-computed values, plus reset-abort and no-wait build checks.
module tb_arm_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;

    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, instr_done;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  flags_q;

    logic        nw_PCWrite, nw_AdrSrc, nw_MemWrite, nw_IRWrite, nw_ALUSrcA, nw_RegWrite;
    logic        nw_instr_done;
    logic [1:0]  nw_ResultSrc, nw_ALUSrcB, nw_ImmSrc, nw_RegSrc;
    logic [2:0]  nw_ALUControl;
    logic [3:0]  nw_flags_q;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_regw, m_memw, m_pcw, m_irw, m_done, m_nw_irw, m_nw_regw;
    int          m_cycles;
    logic [2:0]  m_alu3;
    logic [1:0]  m_srcb3, m_srcb1, m_rs1, m_rs_wb, m_imm1, m_regsrc1;
    logic        m_srca3, m_srca1;

    arm_multicycle_controller #(.ALUCTRL_W(3), .MEM_WAIT_EN(1'b1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .flags_q    (flags_q)
    );

    arm_multicycle_controller #(.ALUCTRL_W(3), .MEM_WAIT_EN(1'b0)) u_dut_nw (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem_ready  (1'b0),
        .PCWrite    (nw_PCWrite),
        .AdrSrc     (nw_AdrSrc),
        .MemWrite   (nw_MemWrite),
        .IRWrite    (nw_IRWrite),
        .ResultSrc  (nw_ResultSrc),
        .ALUSrcA    (nw_ALUSrcA),
        .ALUSrcB    (nw_ALUSrcB),
        .ALUControl (nw_ALUControl),
        .ImmSrc     (nw_ImmSrc),
        .RegSrc     (nw_RegSrc),
        .RegWrite   (nw_RegWrite),
        .instr_done (nw_instr_done),
        .flags_q    (nw_flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH; bit k of nready holds mem_ready low in cycle k+1.
    task automatic run_instr(input logic [31:0] ir, input logic [15:0] nready,
                             input logic [3:0] flags);
        m_regw = '0; m_memw = '0; m_pcw = '0; m_irw = '0; m_done = '0;
        m_nw_irw = '0; m_nw_regw = '0; m_cycles = 0;
        m_alu3 = '0; m_srcb3 = '0; m_srca3 = 1'b0; m_rs_wb = '0;
        Instr    = ir[31:12];
        ALUFlags = flags;
        for (int k = 0; k < 16; k++) begin
            mem_ready = ~nready[k];
            #4;
            m_regw[k]    = RegWrite;
            m_memw[k]    = MemWrite;
            m_pcw[k]     = PCWrite;
            m_irw[k]     = IRWrite;
            m_done[k]    = instr_done;
            m_nw_irw[k]  = nw_IRWrite;
            m_nw_regw[k] = nw_RegWrite;
            if (RegWrite) m_rs_wb = ResultSrc;
            if (k == 0) begin
                m_srca1 = ALUSrcA; m_srcb1 = ALUSrcB; m_rs1 = ResultSrc;
                m_imm1 = ImmSrc; m_regsrc1 = RegSrc;
            end
            if (k == 2) begin
                m_alu3 = ALUControl; m_srcb3 = ALUSrcB; m_srca3 = ALUSrcA;
            end
            @(posedge clk);
            #1;
            if (m_done[k]) begin
                m_cycles = k + 1;
                break;
            end
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        Instr     = 20'hE5921;
        ALUFlags  = 4'b0000;
        mem_ready = 1'b1;
        #3;
        check_eq("rst_outputs", {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, instr_done}, 0);
        check_eq("rst_flags", flags_q, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ADD R1,R2,R3
        run_instr(32'hE0821003, 16'h0000, 4'b0000);
        check_eq("add_cyc", m_cycles, 4);
        check_eq("add_regw", m_regw, 16'h0008);
        check_eq("add_pcw", m_pcw, 16'h0001);
        check_eq("add_irw", m_irw, 16'h0001);
        check_eq("add_done", m_done, 16'h0008);
        check_eq("add_memw", m_memw, 16'h0000);
        check_eq("add_alu", m_alu3, 3'b000);
        check_eq("add_exec_src", {m_srca3, m_srcb3}, 3'b000);
        check_eq("add_fetch_sel", {m_srca1, m_srcb1, m_rs1}, 5'b11010);
        check_eq("add_rs_wb", m_rs_wb, 2'b00);
        check_eq("add_imm_regsrc", {m_imm1, m_regsrc1}, 4'b0000);
        check_eq("nw_irw", m_nw_irw, 16'h0001);
        check_eq("nw_regw", m_nw_regw, 16'h0008);

        // ADD with one fetch wait state
        run_instr(32'hE0821003, 16'h0001, 4'b0000);
        check_eq("addw_cyc", m_cycles, 5);
        check_eq("addw_irw", m_irw, 16'h0002);
        check_eq("addw_regw", m_regw, 16'h0010);

        // LDR, two MEMREAD wait states
        run_instr(32'hE5921004, 16'h0018, 4'b0000);
        check_eq("ldr_cyc", m_cycles, 7);
        check_eq("ldr_regw", m_regw, 16'h0040);
        check_eq("ldr_rs", m_rs_wb, 2'b01);
        check_eq("ldr_memw", m_memw, 16'h0000);
        check_eq("ldr_adr", {m_alu3, m_srcb3}, 5'b00001);
        check_eq("ldr_imm_regsrc", {m_imm1, m_regsrc1}, 4'b0110);

        // STR, no wait then one wait
        run_instr(32'hE5821004, 16'h0000, 4'b0000);
        check_eq("str_cyc", m_cycles, 4);
        check_eq("str_memw", m_memw, 16'h0008);
        check_eq("str_regw", m_regw, 16'h0000);
        run_instr(32'hE5821004, 16'h0008, 4'b0000);
        check_eq("strw_cyc", m_cycles, 5);
        check_eq("strw_memw", m_memw, 16'h0018);
        check_eq("strw_done", m_done, 16'h0010);

        // SUBS sets Z, then BEQ taken
        run_instr(32'hE0521003, 16'h0000, 4'b0100);
        check_eq("subs_alu", m_alu3, 3'b001);
        check_eq("subs_flags", flags_q, 4'b0100);
        run_instr(32'h0A000002, 16'h0000, 4'b0000);
        check_eq("beq_t_cyc", m_cycles, 3);
        check_eq("beq_t_pcw", m_pcw, 16'h0005);
        check_eq("beq_t_regw", m_regw, 16'h0000);
        check_eq("beq_t_srcb", m_srcb3, 2'b01);
        check_eq("beq_imm_regsrc", {m_imm1, m_regsrc1}, 4'b1001);

        // ADDS clears flags, then BEQ not taken
        run_instr(32'hE0921003, 16'h0000, 4'b0000);
        check_eq("adds_flags", flags_q, 4'b0000);
        run_instr(32'h0A000002, 16'h0000, 4'b0000);
        check_eq("beq_nt_cyc", m_cycles, 2);
        check_eq("beq_nt_pcw", m_pcw, 16'h0001);
        check_eq("beq_nt_done", m_done, 16'h0002);

        // CMP then ANDS (logical keeps C,V)
        run_instr(32'hE1510002, 16'h0000, 4'b0110);
        check_eq("cmp_cyc", m_cycles, 3);
        check_eq("cmp_regw", m_regw, 16'h0000);
        check_eq("cmp_alu", m_alu3, 3'b001);
        check_eq("cmp_flags", flags_q, 4'b0110);
        run_instr(32'hE0121003, 16'h0000, 4'b1011);
        check_eq("ands_alu", m_alu3, 3'b010);
        check_eq("ands_flags", flags_q, 4'b1010);

        // ORR immediate without S, EOR register
        run_instr(32'hE3821003, 16'h0000, 4'b0101);
        check_eq("orri_alu_src", {m_alu3, m_srcb3}, 5'b01101);
        check_eq("orri_flags", flags_q, 4'b1010);
        run_instr(32'hE0221003, 16'h0000, 4'b0000);
        check_eq("eor_alu", m_alu3, 3'b100);

        // ADD to PC, BL, cond 1111, op 11
        run_instr(32'hE082F003, 16'h0000, 4'b0000);
        check_eq("addpc_pcw", m_pcw, 16'h0009);
        check_eq("addpc_regw", m_regw, 16'h0000);
        run_instr(32'hEB000000, 16'h0000, 4'b0000);
        check_eq("bl_cyc", m_cycles, 3);
        check_eq("bl_regw", m_regw, 16'h0004);
        check_eq("bl_pcw", m_pcw, 16'h0005);
        run_instr(32'hF0821003, 16'h0000, 4'b0000);
        check_eq("nv_cyc", m_cycles, 2);
        check_eq("nv_writes", {m_regw, m_memw}, 32'h0);
        run_instr(32'hEC000000, 16'h0000, 4'b0000);
        check_eq("op11_cyc", m_cycles, 2);
        check_eq("op11_writes", {m_regw, m_memw, m_pcw}, 48'h000000000001);

        // LDR into PC, then BLT with N=1,V=0
        run_instr(32'hE592F004, 16'h0000, 4'b0000);
        check_eq("ldrpc_pcw", m_pcw, 16'h0011);
        check_eq("ldrpc_regw", m_regw, 16'h0010);
        run_instr(32'hBA000000, 16'h0000, 4'b0000);
        check_eq("blt_cyc", m_cycles, 3);

        // Reset asserted while MEMWRITE waits on memory
        Instr     = 20'hE5821;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        #2;
        check_eq("abort_pre_memw", {MemWrite, AdrSrc}, 2'b11);
        reset = 1'b0;
        #1;
        check_eq("abort_outputs", {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, instr_done}, 0);
        check_eq("abort_flags", flags_q, 4'b0000);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #2;
        check_eq("abort_fetch", {IRWrite, ALUSrcB, MemWrite}, 4'b1100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
